// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types for the single-port memory FIFO controller
//
// Holds the access-priority state used to arbitrate the one memory port
// between the push (write) side and the prefetch (read) side.

package mem_pkg;

  // PRIO_RD: a pending read wins the port this cycle.
  // PRIO_WR: a pending write wins the port this cycle.
  typedef enum logic {
    PRIO_RD = 1'b0,
    PRIO_WR = 1'b1
  } prio_t;

endpackage : mem_pkg

// File: rtl/mem_fifo_ctrl.sv
// rtl/mem_fifo_ctrl.sv - FIFO controller over a single-port, async-read memory
//
// Ports:
//   clk, rst           single clock, asynchronous active-high reset
//   in_valid/in_ready  push handshake, in_data is the pushed word
//   out_valid/out_ready pop handshake, out_data is the registered head word
//   count              words held in memory plus the output register
//   full               memory holds DEPTH words
//   empty              count == 0
//   mem_we, mem_addr, mem_wdata, mem_rdata
//                      port to the external single-port memory; mem_rdata is
//                      combinational read data for mem_addr

module mem_fifo_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   mem_cnt;
  prio_t                 prio;
  prio_t                 prio_next;

  logic rd_req;
  logic wr_gnt;
  logic rd_gnt;

  // A read is wanted whenever memory has data and the output register is
  // free or being drained this cycle. Neither request looks at in_valid, so
  // in_ready never combinationally depends on the producer.
  always_comb begin
    rd_req   = 1'b0;
    in_ready = 1'b0;
    wr_gnt   = 1'b0;
    rd_gnt   = 1'b0;

    rd_req   = (mem_cnt != '0) && (!out_valid || out_ready);
    in_ready = !rst && (mem_cnt != DEPTH_CNT) && !(rd_req && (prio == PRIO_RD));
    wr_gnt   = in_valid && in_ready;
    rd_gnt   = rd_req && !wr_gnt;
  end

  // The write address takes the shared port only on a granted push.
  assign mem_we    = wr_gnt;
  assign mem_wdata = in_data;
  assign mem_addr  = wr_gnt ? wr_ptr : rd_ptr;

  assign full  = (mem_cnt == DEPTH_CNT);
  assign count = mem_cnt + (ADDR_WIDTH+1)'(out_valid);
  assign empty = (count == '0);

  // Priority flips to the side that did not just use the port, so under
  // contention reads and writes alternate.
  always_comb begin
    prio_next = prio;
    if (rd_gnt) begin
      prio_next = PRIO_WR;
    end else if (wr_gnt) begin
      prio_next = PRIO_RD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio <= PRIO_RD;
    end else begin
      prio <= prio_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (wr_gnt) begin
        wr_ptr  <= wr_ptr + ADDR_WIDTH'(1);
        mem_cnt <= mem_cnt + (ADDR_WIDTH+1)'(1);
      end else if (rd_gnt) begin
        rd_ptr  <= rd_ptr + ADDR_WIDTH'(1);
        mem_cnt <= mem_cnt - (ADDR_WIDTH+1)'(1);
      end

      // A refill overrides the drain: the consumer takes the old word and
      // the freshly read word replaces it in the same edge.
      if (rd_gnt) begin
        out_data  <= mem_rdata;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule : mem_fifo_ctrl

// File: tb/tb_mem_fifo_ctrl.sv
// tb/tb_mem_fifo_ctrl.sv - self-checking bench for mem_fifo_ctrl with a 4-word memory

module tb_mem_fifo_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] mem [DEPTH];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Attached single-port memory: synchronous write, asynchronous read.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = mem[mem_addr];

  typedef struct {
    logic          iv;
    logic [DW-1:0] id;
    logic          ordy;
    logic          e_ir;
    logic          e_we;
    logic          e_ov;
    logic [DW-1:0] e_od;
    int            e_cnt;
    logic          e_full;
  } vec_t;

  vec_t vec [13];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic drive(input logic iv, input logic [DW-1:0] d, input logic ordy);
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] mq [$];
    logic [DW-1:0] sb [$];
    logic [DW-1:0] w3 [3];
    logic          m_ov;
    logic [DW-1:0] m_od;
    bit            m_prio_wr;
    bit            iv, ordy, rd_req, e_ir, wr, rd;
    logic [DW-1:0] d;
    logic          prev_we;
    int            k;
    int            seen;

    vec[0]  = '{1'b1, 8'hA0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 0, 1'b0};
    vec[1]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1, 1'b0};
    vec[2]  = '{1'b1, 8'hA1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA0, 1, 1'b0};
    vec[3]  = '{1'b1, 8'hA2, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA0, 2, 1'b0};
    vec[4]  = '{1'b1, 8'hA3, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA0, 3, 1'b0};
    vec[5]  = '{1'b1, 8'hA4, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA0, 4, 1'b0};
    vec[6]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA0, 5, 1'b1};
    vec[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA0, 5, 1'b1};
    vec[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA1, 4, 1'b0};
    vec[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA2, 3, 1'b0};
    vec[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA3, 2, 1'b0};
    vec[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA4, 1, 1'b0};
    vec[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;

    // Reset state, with a push attempt held against reset.
    repeat (2) @(negedge clk);
    in_valid = 1'b1;
    #1;
    chk("rst.in_ready",  in_ready,  0);
    chk("rst.mem_we",    mem_we,    0);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.count",     count,     0);
    chk("rst.empty",     empty,     1);
    chk("rst.full",      full,      0);
    in_valid = 1'b0;
    rst = 1'b0;

    // Fill to DEPTH+1 words, then drain in order.
    for (int i = 0; i < 13; i++) begin
      drive(vec[i].iv, vec[i].id, vec[i].ordy);
      chk($sformatf("vec%0d.in_ready", i),  in_ready,  vec[i].e_ir);
      chk($sformatf("vec%0d.mem_we", i),    mem_we,    vec[i].e_we);
      chk($sformatf("vec%0d.out_valid", i), out_valid, vec[i].e_ov);
      if (vec[i].e_ov) chk($sformatf("vec%0d.out_data", i), out_data, vec[i].e_od);
      chk($sformatf("vec%0d.count", i),     count,     vec[i].e_cnt);
      chk($sformatf("vec%0d.full", i),      full,      vec[i].e_full);
      chk($sformatf("vec%0d.empty", i),     empty,     vec[i].e_cnt == 0);
    end

    // Latency: pushed at edge N, out_valid visible after edge N+1.
    do_reset();
    drive(1'b1, 8'h11, 1'b1);
    chk("lat.push_ready", in_ready, 1);
    drive(1'b0, 8'h00, 1'b1);
    chk("lat.valid_n", out_valid, 0);
    drive(1'b0, 8'h00, 1'b1);
    chk("lat.valid_n1", out_valid, 1);
    chk("lat.data", out_data, 8'h11);
    drive(1'b0, 8'h00, 1'b1);
    chk("lat.valid_after", out_valid, 0);
    chk("lat.count_after", count, 0);

    // Contention: memory port alternates between write and read.
    do_reset();
    k = 0;
    for (int c = 0; c < 20 && k < 2; c++) begin
      drive(1'b1, 8'(8'h30 + k), 1'b0);
      if (in_ready) k++;
    end
    drive(1'b1, 8'h40, 1'b1);
    prev_we = mem_we;
    for (int c = 0; c < 8; c++) begin
      drive(1'b1, 8'(8'h41 + c), 1'b1);
      chk($sformatf("alt%0d.mem_we", c), mem_we, !prev_we);
      prev_we = mem_we;
    end

    // Reset with three words held discards them; later traffic is clean.
    do_reset();
    w3[0] = 8'hC1; w3[1] = 8'hC2; w3[2] = 8'hC3;
    k = 0;
    for (int c = 0; c < 20 && k < 3; c++) begin
      drive(1'b1, w3[k], 1'b0);
      if (in_ready) k++;
    end
    drive(1'b0, 8'h00, 1'b0);
    chk("midrst.count_before", count, 3);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    #1;
    chk("midrst.out_valid", out_valid, 0);
    chk("midrst.count", count, 0);
    chk("midrst.in_ready", in_ready, 0);
    @(negedge clk);
    #1;
    chk("midrst.in_ready_held", in_ready, 0);
    chk("midrst.mem_we_held", mem_we, 0);
    rst = 1'b0;
    in_valid = 1'b0;
    drive(1'b1, 8'h5A, 1'b1);
    chk("midrst.push_ready", in_ready, 1);
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b1);
    chk("midrst.valid", out_valid, 1);
    chk("midrst.data", out_data, 8'h5A);

    // Randomized traffic against a queue-level model of the controller.
    do_reset();
    mq.delete(); sb.delete();
    m_ov = 1'b0; m_od = '0; m_prio_wr = 1'b0;
    seen = 0;
    for (int c = 0; c < 500; c++) begin
      if (c < 100) begin
        iv = ($urandom_range(3) != 0); ordy = ($urandom_range(3) == 0);
      end else if (c < 200) begin
        iv = ($urandom_range(3) == 0); ordy = ($urandom_range(3) != 0);
      end else if (c < 260) begin
        iv = 1'b1; ordy = 1'b1;
      end else begin
        iv = $urandom_range(1); ordy = $urandom_range(1);
      end
      d = 8'($urandom);
      drive(iv, d, ordy);

      rd_req = (mq.size() > 0) && (!m_ov || ordy);
      e_ir   = (mq.size() < DEPTH) && !(rd_req && !m_prio_wr);
      wr     = iv && e_ir;
      rd     = rd_req && !wr;

      chk("rnd.in_ready",  in_ready,  e_ir);
      chk("rnd.mem_we",    mem_we,    wr);
      chk("rnd.out_valid", out_valid, m_ov);
      if (m_ov) chk("rnd.out_data", out_data, m_od);
      chk("rnd.count",     count,     mq.size() + int'(m_ov));
      chk("rnd.full",      full,      mq.size() == DEPTH);
      chk("rnd.empty",     empty,     (mq.size() + int'(m_ov)) == 0);

      // Independent order scoreboard on the actual handshakes.
      if (in_valid && in_ready) sb.push_back(in_data);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("rnd.sb_underflow", 1, 0);
        end else begin
          chk("rnd.sb_order", out_data, sb.pop_front());
          seen++;
        end
      end

      if (rd) begin
        m_od = mq.pop_front();
        m_ov = 1'b1;
        m_prio_wr = 1'b1;
      end else if (m_ov && ordy) begin
        m_ov = 1'b0;
      end
      if (wr) begin
        mq.push_back(d);
        m_prio_wr = 1'b0;
      end
    end
    chk("rnd.enough_pops", seen > 10, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mem_fifo_ctrl
